// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, jump flushes and data-memory wait stalls,
// plus running counters of stalled cycles and redirects acted on.
module hazard_ctrl #(
  parameter int LOAD_STALL_CYCLES = 2,
  parameter int FLUSH_CYCLES      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  decode_rs1,
  input  logic [4:0]  decode_rs2,
  input  logic        decode_uses_rs2,
  input  logic        decode_jump,
  input  logic [4:0]  execute_rd,
  input  logic [1:0]  execute_result_src,
  input  logic        execute_regfile_wr_enable,
  input  logic        dmem_busy,
  output logic        pc_stall,
  output logic        ifid_stall,
  output logic        idex_stall,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_bubble,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
);

  // state      | meaning
  // RUN        | no hazard in progress
  // LOAD_STALL | holding for load-use; leaves when the decremented cnt reaches 0
  // JUMP_FLUSH | extra IF/ID flush cycles after a redirect; leaves when cnt is 0
  // MEM_WAIT   | data memory busy, whole front end held
  typedef enum logic [1:0] {RUN, LOAD_STALL, JUMP_FLUSH, MEM_WAIT} state_e;

  localparam logic [2:0] LOAD_INIT  = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] stall_count_q, stall_count_d;
  logic [31:0] flush_count_q, flush_count_d;
  logic        load_use;
  logic        jump_taken;

  assign load_use = (execute_result_src == 2'b01) && execute_regfile_wr_enable &&
                    (execute_rd != 5'd0) &&
                    ((execute_rd == decode_rs1) ||
                     (decode_uses_rs2 && (execute_rd == decode_rs2)));

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pc_stall     = 1'b0;
    ifid_stall   = 1'b0;
    idex_stall   = 1'b0;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_bubble = 1'b0;
    jump_taken   = 1'b0;

    if (rst) begin
      state_d = RUN;
      cnt_d   = 3'd0;
    end else if (dmem_busy) begin
      // EX/MEM is held, so no bubble and no flush; cnt is frozen in every state
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      idex_stall = 1'b1;
      if (state_q == RUN) state_d = MEM_WAIT;
    end else begin
      unique case (state_q)
        RUN, MEM_WAIT: begin
          state_d = RUN;
          if (load_use) begin
            pc_stall     = 1'b1;
            ifid_stall   = 1'b1;
            idex_stall   = 1'b1;
            exmem_bubble = 1'b1;
            cnt_d        = LOAD_INIT;
            if (LOAD_INIT != 3'd0) state_d = LOAD_STALL;
          end else if (decode_jump) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            jump_taken = 1'b1;
            if (FLUSH_CYCLES > 0) begin
              cnt_d   = FLUSH_INIT;
              state_d = JUMP_FLUSH;
            end
          end
        end
        LOAD_STALL: begin
          pc_stall     = 1'b1;
          ifid_stall   = 1'b1;
          idex_stall   = 1'b1;
          exmem_bubble = 1'b1;
          cnt_d        = cnt_q - 3'd1;
          if (cnt_q <= 3'd1) begin
            cnt_d   = 3'd0;
            state_d = RUN;
          end
        end
        JUMP_FLUSH: begin
          ifid_flush = 1'b1;
          if (cnt_q == 3'd0) begin
            state_d = RUN;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    flush_count_d = flush_count_q;
    if (pc_stall)   stall_count_d = stall_count_q + 32'd1;
    if (jump_taken) flush_count_d = flush_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      cnt_q         <= 3'd0;
      stall_count_q <= 32'd0;
      flush_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      stall_count_q <= stall_count_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign stall_count = stall_count_q;
  assign flush_count = flush_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed hazard scenarios followed by random traffic,
// checked every cycle against a pending-cycles reference model.
module tb_hazard_ctrl;
  localparam int L = 2;
  localparam int F = 1;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [4:0]  decode_rs1, decode_rs2, execute_rd;
  logic        decode_uses_rs2, decode_jump, execute_regfile_wr_enable, dmem_busy;
  logic [1:0]  execute_result_src;
  logic        pc_stall, ifid_stall, idex_stall, ifid_flush, idex_flush, exmem_bubble;
  logic [31:0] stall_count, flush_count;

  hazard_ctrl #(.LOAD_STALL_CYCLES(L), .FLUSH_CYCLES(F)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .decode_rs1                (decode_rs1),
    .decode_rs2                (decode_rs2),
    .decode_uses_rs2           (decode_uses_rs2),
    .decode_jump               (decode_jump),
    .execute_rd                (execute_rd),
    .execute_result_src        (execute_result_src),
    .execute_regfile_wr_enable (execute_regfile_wr_enable),
    .dmem_busy                 (dmem_busy),
    .pc_stall                  (pc_stall),
    .ifid_stall                (ifid_stall),
    .idex_stall                (idex_stall),
    .ifid_flush                (ifid_flush),
    .idex_flush                (idex_flush),
    .exmem_bubble              (exmem_bubble),
    .stall_count               (stall_count),
    .flush_count               (flush_count)
  );

  // ctl = {pc_stall, ifid_stall, idex_stall, ifid_flush, idex_flush, exmem_bubble}
  typedef struct packed {
    logic [5:0]  ctl;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          stall_left = 0;
  int          flush_left = 0;
  logic [31:0] m_sc = 32'd0;
  logic [31:0] m_fc = 32'd0;

  function automatic logic is_load_use(input logic [4:0] rs1, rs2, rd, input logic u2,
                                       input logic [1:0] src, input logic we);
    return (src == 2'b01) && we && (rd != 5'd0) && ((rd == rs1) || (u2 && (rd == rs2)));
  endfunction

  // Reference: a busy memory holds everything; otherwise remaining stall cycles,
  // then remaining flush cycles, then a new hazard, then a new jump.
  task automatic model_push();
    exp_t       e;
    logic [5:0] c;
    c    = 6'b000000;
    e.sc = m_sc;
    e.fc = m_fc;
    if (rst) begin
      stall_left = 0;
      flush_left = 0;
      m_sc = 32'd0;
      m_fc = 32'd0;
    end else begin
      if (dmem_busy) begin
        c = 6'b111000;
      end else if (stall_left > 0) begin
        c = 6'b111001;
        stall_left--;
      end else if (flush_left > 0) begin
        c = 6'b000100;
        flush_left--;
      end else if (is_load_use(decode_rs1, decode_rs2, execute_rd, decode_uses_rs2,
                               execute_result_src, execute_regfile_wr_enable)) begin
        c = 6'b111001;
        stall_left = L - 1;
      end else if (decode_jump) begin
        c = 6'b000110;
        flush_left = F;
        m_fc = m_fc + 32'd1;
      end
      if (c[5]) m_sc = m_sc + 32'd1;
    end
    e.ctl = c;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic r, input logic [4:0] rs1, rs2, input logic u2, j,
                       input logic [4:0] rd, input logic [1:0] src, input logic we, busy);
    @(posedge clk);
    #1;
    rst = r;
    decode_rs1 = rs1;
    decode_rs2 = rs2;
    decode_uses_rs2 = u2;
    decode_jump = j;
    execute_rd = rd;
    execute_result_src = src;
    execute_regfile_wr_enable = we;
    dmem_busy = busy;
    model_push();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) drive(1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("ctl", {26'd0, pc_stall, ifid_stall, idex_stall, ifid_flush, idex_flush,
                    exmem_bubble}, {26'd0, e.ctl});
        chk("stall_count", stall_count, e.sc);
        chk("flush_count", flush_count, e.fc);
      end
    end
  end

  initial begin
    rst = 1'b1;
    decode_rs1 = 5'd0; decode_rs2 = 5'd0; decode_uses_rs2 = 1'b0; decode_jump = 1'b0;
    execute_rd = 5'd0; execute_result_src = 2'b00; execute_regfile_wr_enable = 1'b0;
    dmem_busy = 1'b0;
    repeat (2) @(posedge clk);
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 2'b00, 1'b0, 1'b0);
    drive(1'b1, 5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 2'b01, 1'b1, 1'b1);
    idle(2);

    // load x5 feeding rs1: held 2 cycles
    repeat (2) drive(1'b0, 5'd5, 5'd3, 1'b0, 1'b0, 5'd5, 2'b01, 1'b1, 1'b0);
    idle(2);
    // load to x0 and ALU writer: no stall
    drive(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 2'b01, 1'b1, 1'b0);
    drive(1'b0, 5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 2'b00, 1'b1, 1'b0);
    // rs2 hazard only when rs2 is used
    drive(1'b0, 5'd1, 5'd7, 1'b0, 1'b0, 5'd7, 2'b01, 1'b1, 1'b0);
    repeat (2) drive(1'b0, 5'd1, 5'd7, 1'b1, 1'b0, 5'd7, 2'b01, 1'b1, 1'b0);
    idle(1);
    // one-cycle jump
    drive(1'b0, 5'd1, 5'd2, 1'b0, 1'b1, 5'd0, 2'b00, 1'b0, 1'b0);
    idle(3);
    // busy for 3 cycles inside the load stall
    drive(1'b0, 5'd9, 5'd0, 1'b0, 1'b0, 5'd9, 2'b01, 1'b1, 1'b0);
    repeat (3) drive(1'b0, 5'd9, 5'd0, 1'b0, 1'b0, 5'd9, 2'b01, 1'b1, 1'b1);
    drive(1'b0, 5'd9, 5'd0, 1'b0, 1'b0, 5'd9, 2'b01, 1'b1, 1'b0);
    idle(2);
    // load-use with a jump: stall first, flush afterwards
    repeat (2) drive(1'b0, 5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 2'b01, 1'b1, 1'b0);
    drive(1'b0, 5'd4, 5'd0, 1'b0, 1'b1, 5'd0, 2'b00, 1'b0, 1'b0);
    idle(3);
    // reset in the middle of a load stall
    drive(1'b0, 5'd6, 5'd0, 1'b0, 1'b0, 5'd6, 2'b01, 1'b1, 1'b0);
    drive(1'b1, 5'd6, 5'd0, 1'b0, 1'b0, 5'd6, 2'b01, 1'b1, 1'b0);
    idle(2);
    // reset in the middle of a jump flush
    drive(1'b0, 5'd1, 5'd2, 1'b0, 1'b1, 5'd0, 2'b00, 1'b0, 1'b0);
    drive(1'b1, 5'd1, 5'd2, 1'b0, 1'b1, 5'd0, 2'b00, 1'b0, 1'b0);
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(99) == 0, 5'($urandom_range(3)), 5'($urandom_range(3)),
            1'($urandom_range(1)), $urandom_range(3) == 0, 5'($urandom_range(3)),
            2'($urandom_range(3)), 1'($urandom_range(1)), $urandom_range(5) == 0);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
